// File: rtl/ram_device_pkg.sv
// Shared bus constants for the RAM device: request bits, status codes and
// the wait-counter width.
`ifndef WORD_WIDTH
`define WORD_WIDTH 16
`endif

package ram_device_pkg;

    // Request bit positions inside the controller's ctrl word.
    localparam int CTRL_READ  = 0;
    localparam int CTRL_WRITE = 1;

    // Status codes returned on the stat word.
    localparam int unsigned STAT_IDLE = 0;
    localparam int unsigned STAT_BUSY = 1;
    localparam int unsigned STAT_DONE = 2;
    localparam int unsigned STAT_ERR  = 3;

    // The wait counter is sized for the largest legal WAIT_CYCLES (255).
    localparam int CNT_W = 8;

endpackage

// File: rtl/ram_device_array.sv
// Single-port synchronous RAM. The read port registers mem[a] on every edge.
// A write returns the old contents on q; the device never depends on that.
module ram_device_array #(
    parameter int WORD_WIDTH = 16,
    parameter int ADDR_BITS  = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_BITS-1:0]  a,
    input  logic [WORD_WIDTH-1:0] d,
    output logic [WORD_WIDTH-1:0] q
);

    logic [WORD_WIDTH-1:0] mem [0:(1 << ADDR_BITS)-1];

    // Write on we, and always register the word at the current address.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[a] <= d;
        end
        q <= mem[a];
    end

endmodule

// File: rtl/ram_device.sv
// Bus-side RAM target. A request is accepted in IDLE and waits WAIT_CYCLES
// in BUSY. The op then commits, and DONE/ERR is held until ctrl returns to zero.
`ifndef WORD_WIDTH
`define WORD_WIDTH 16
`endif

module ram_device
    import ram_device_pkg::*;
#(
    parameter int WORD_WIDTH  = `WORD_WIDTH,
    parameter int ADDR_BITS   = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WORD_WIDTH-1:0] ctrl,
    output logic [WORD_WIDTH-1:0] stat,
    input  logic [WORD_WIDTH-1:0] addr,
    input  logic [WORD_WIDTH-1:0] wdata,
    output logic [WORD_WIDTH-1:0] rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_BITS-1:0]  addr_q, addr_d;
    logic [WORD_WIDTH-1:0] wdata_q, wdata_d;
    logic                  is_wr_q, is_wr_d;
    logic [WORD_WIDTH-1:0] stat_q, stat_d;
    logic [WORD_WIDTH-1:0] rdata_q, rdata_d;

    logic                  req_rd, req_wr, out_of_range, commit;
    logic                  ram_we;
    logic [ADDR_BITS-1:0]  ram_a;
    logic [WORD_WIDTH-1:0] ram_q;

    // READ has priority when both bits are set, so the op becomes a pure read.
    assign req_rd       = ctrl[CTRL_READ];
    assign req_wr       = ctrl[CTRL_WRITE] & ~ctrl[CTRL_READ];
    assign out_of_range = (addr >> ADDR_BITS) != '0;
    assign commit       = (state_q == S_BUSY) && (cnt_q == CNT_W'(1));

    // In IDLE the array is pointed at the live bus address. The accepting edge
    // then pre-reads the target word, so q is valid by the commit edge even
    // when WAIT_CYCLES is 1. After that edge the latched address holds it.
    assign ram_a  = (state_q == S_IDLE) ? addr[ADDR_BITS-1:0] : addr_q;
    assign ram_we = commit & is_wr_q;

    ram_device_array #(
        .WORD_WIDTH(WORD_WIDTH),
        .ADDR_BITS (ADDR_BITS)
    ) u_array (
        .clk(clk),
        .we (ram_we),
        .a  (ram_a),
        .d  (wdata_q),
        .q  (ram_q)
    );

    // Next-state, counter, request latch, status and read-data update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        is_wr_d = is_wr_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_rd || req_wr) begin
                    if (out_of_range) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_BUSY;
                        cnt_d   = CNT_W'(WAIT_CYCLES);
                        addr_d  = addr[ADDR_BITS-1:0];
                        wdata_d = wdata;
                        is_wr_d = req_wr;
                    end
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (commit) begin
                    state_d = S_DONE;
                    if (!is_wr_q) begin
                        rdata_d = ram_q;
                    end
                end
            end
            S_DONE, S_ERR: begin
                if (ctrl == '0) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        case (state_d)
            S_BUSY:  stat_d = WORD_WIDTH'(STAT_BUSY);
            S_DONE:  stat_d = WORD_WIDTH'(STAT_DONE);
            S_ERR:   stat_d = WORD_WIDTH'(STAT_ERR);
            default: stat_d = WORD_WIDTH'(STAT_IDLE);
        endcase
    end

    // State registers. Reset aborts any in-flight op and clears rdata.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            is_wr_q <= 1'b0;
            stat_q  <= WORD_WIDTH'(STAT_IDLE);
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            is_wr_q <= is_wr_d;
            stat_q  <= stat_d;
            rdata_q <= rdata_d;
        end
    end

    assign stat  = stat_q;
    assign rdata = rdata_q;

endmodule

// File: tb/tb_ram_device.sv
// Directed bench for ram_device with WORD_WIDTH=16, ADDR_BITS=10 and WAIT_CYCLES=2.
module tb_ram_device;
    import ram_device_pkg::*;

    localparam int W  = 16;
    localparam int WC = 2;

    localparam logic [W-1:0] RD   = 16'h0001;
    localparam logic [W-1:0] WR   = 16'h0002;
    localparam logic [W-1:0] BOTH = 16'h0003;

    localparam logic [W-1:0] S_IDLE = W'(STAT_IDLE);
    localparam logic [W-1:0] S_BUSY = W'(STAT_BUSY);
    localparam logic [W-1:0] S_DONE = W'(STAT_DONE);
    localparam logic [W-1:0] S_ERR  = W'(STAT_ERR);

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] ctrl, stat, addr, wdata, rdata;

    int n_pass = 0;
    int n_tot  = 0;

    ram_device #(.WORD_WIDTH(W), .ADDR_BITS(10), .WAIT_CYCLES(WC)) dut (
        .clk(clk), .rst(rst), .ctrl(ctrl), .stat(stat),
        .addr(addr), .wdata(wdata), .rdata(rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [W-1:0] ctrl;
        logic [W-1:0] addr;
        logic [W-1:0] wdata;
        bit           err;
        logic [W-1:0] exp_rd;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full handshake. The request is sampled at the next edge, DONE/ERR is
    // held for one extra cycle, then ctrl drops and IDLE is checked.
    task automatic txn(input string name, input logic [W-1:0] c, input logic [W-1:0] a,
                       input logic [W-1:0] d, input bit err, input logic [W-1:0] exp_rd);
        ctrl = c; addr = a; wdata = d;
        tick();
        if (err) begin
            chk({name, " err"}, stat, S_ERR);
            tick();
            chk({name, " err held"}, stat, S_ERR);
        end else begin
            chk({name, " busy0"}, stat, S_BUSY);
            for (int i = 1; i < WC; i++) begin
                tick();
                chk({name, " busy"}, stat, S_BUSY);
            end
            tick();
            chk({name, " done"}, stat, S_DONE);
            chk({name, " rdata"}, rdata, exp_rd);
            tick();
            chk({name, " done held"}, stat, S_DONE);
        end
        ctrl = '0;
        tick();
        chk({name, " idle"}, stat, S_IDLE);
        chk({name, " rdata end"}, rdata, exp_rd);
    endtask

    initial begin
        vecs[0] = '{"wr5",      WR,   16'h0005, 16'h1234, 1'b0, 16'h0000};
        vecs[1] = '{"rd5",      RD,   16'h0005, 16'h0000, 1'b0, 16'h1234};
        vecs[2] = '{"wr7",      WR,   16'h0007, 16'hAAAA, 1'b0, 16'h1234};
        vecs[3] = '{"both7",    BOTH, 16'h0007, 16'h5555, 1'b0, 16'hAAAA};
        vecs[4] = '{"rd7",      RD,   16'h0007, 16'h0000, 1'b0, 16'hAAAA};
        vecs[5] = '{"oor_rd",   RD,   16'h0400, 16'h0000, 1'b1, 16'hAAAA};
        vecs[6] = '{"oor_wr",   WR,   16'h8001, 16'h9999, 1'b1, 16'hAAAA};
        vecs[7] = '{"wr3ff",    WR,   16'h03FF, 16'hCAFE, 1'b0, 16'hAAAA};
        vecs[8] = '{"rd3ff",    RD,   16'h03FF, 16'h0000, 1'b0, 16'hCAFE};
        vecs[9] = '{"rd7again", RD,   16'h0007, 16'h0000, 1'b0, 16'hAAAA};

        rst = 1'b1; ctrl = '0; addr = '0; wdata = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset stat", stat, S_IDLE);
        chk("reset rdata", rdata, 16'h0000);

        // A nonzero ctrl with neither op bit set must leave the device idle.
        ctrl = 16'h0004; addr = 16'h0005;
        tick();
        chk("noop idle", stat, S_IDLE);
        tick();
        chk("noop idle2", stat, S_IDLE);
        ctrl = '0;
        tick();

        foreach (vecs[i])
            txn(vecs[i].name, vecs[i].ctrl, vecs[i].addr, vecs[i].wdata, vecs[i].err, vecs[i].exp_rd);

        // Drop ctrl during BUSY: the write still lands and DONE shows for one cycle.
        ctrl = WR; addr = 16'h0003; wdata = 16'hBEEF;
        tick();
        chk("drop busy0", stat, S_BUSY);
        ctrl = '0;
        tick();
        chk("drop busy1", stat, S_BUSY);
        tick();
        chk("drop done", stat, S_DONE);
        tick();
        chk("drop idle", stat, S_IDLE);
        txn("rd3", RD, 16'h0003, 16'h0000, 1'b0, 16'hBEEF);

        // Reset while BUSY: the pending write is dropped and rdata clears.
        txn("wr9", WR, 16'h0009, 16'h1111, 1'b0, 16'hBEEF);
        ctrl = WR; addr = 16'h0009; wdata = 16'h0F0F;
        tick();
        chk("rstbusy busy", stat, S_BUSY);
        #2 rst = 1'b1;
        #1;
        chk("rstbusy stat", stat, S_IDLE);
        chk("rstbusy rdata", rdata, 16'h0000);
        ctrl = '0;
        tick();
        rst = 1'b0;
        txn("rd9", RD, 16'h0009, 16'h0000, 1'b0, 16'h1111);

        // Back-to-back: release at edge m, then a new read is sampled at edge m+1.
        ctrl = RD; addr = 16'h0005;
        tick();
        tick();
        tick();
        chk("b2b done", stat, S_DONE);
        chk("b2b rdata", rdata, 16'h1234);
        ctrl = '0;
        tick();
        chk("b2b release idle", stat, S_IDLE);
        ctrl = RD; addr = 16'h0007;
        tick();
        chk("b2b accept busy", stat, S_BUSY);
        tick();
        tick();
        chk("b2b done2", stat, S_DONE);
        chk("b2b rdata2", rdata, 16'hAAAA);
        ctrl = '0;
        tick();
        chk("b2b idle2", stat, S_IDLE);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
